// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
package mult_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_FIN  = FIN
  } state_e;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/shift_operand_sel.sv
// Produces the multiplicand shifted by the current bit index, gated by that multiplier bit.
module shift_operand_sel
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]             i_a,
  input  logic [WIDTH-1:0]             i_b,
  input  logic [$clog2(WIDTH)-1:0]     i_idx,
  output logic [prod_width(WIDTH)-1:0] o_addend
);

  localparam int PW = prod_width(WIDTH);

  logic [PW-1:0] w_a_ext;

  assign w_a_ext  = {{WIDTH{1'b0}}, i_a};
  assign o_addend = i_b[i_idx] ? (w_a_ext << i_idx) : '0;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: one multiplier bit per cycle into a shared 2*WIDTH adder.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         START,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  output logic                         READY,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [prod_width(WIDTH)-1:0] P,
  output logic [$clog2(WIDTH)-1:0]     SHAMT
);

  localparam int PW = prod_width(WIDTH);
  localparam int IW = $clog2(WIDTH);

  state_e          r_state;
  state_e          w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [IW-1:0]    r_idx;

  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_sum;
  logic [IW:0]      w_idx_nxt;
  logic             w_last;

  shift_operand_sel #(.WIDTH(WIDTH)) u_sel (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_idx    (r_idx),
    .o_addend (w_addend)
  );

  assign w_sum     = r_acc + w_addend;
  // One bit wider so the look-ahead shift at the top index does not wrap to zero.
  assign w_idx_nxt = {1'b0, r_idx} + (IW+1)'(1);
  assign w_last    = (r_idx == IW'(WIDTH-1)) ||
                     (EARLY_TERM && ((r_b >> w_idx_nxt) == '0));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (START) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a   <= A;
            r_b   <= B;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          if (w_last) r_p   <= w_sum;
          else        r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // READY is masked by reset so every output reads zero while reset is held.
  assign READY = (r_state == S_IDLE) && RST_N;
  assign BUSY  = (r_state == S_RUN);
  assign DONE  = (r_state == S_FIN);
  assign P     = r_p;
  assign SHAMT = r_idx;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench: instance 0 uses early termination, instance 1 always runs all steps.
module tb_shift_add_mult_ctrl;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] n;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start [2];
  logic [15:0] a     [2];
  logic [15:0] b     [2];
  logic        ready [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] p     [2];
  logic [3:0]  shamt [2];

  exp_t        q0[$];
  exp_t        q1[$];
  int          busy_cnt  [2];
  logic        done_prev [2];
  int          n_checks;
  int          n_errors;

  shift_add_mult_ctrl #(.WIDTH(16), .EARLY_TERM(1'b1)) u_dut_et (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .A(a[0]), .B(b[0]),
    .READY(ready[0]), .BUSY(busy[0]), .DONE(done[0]), .P(p[0]), .SHAMT(shamt[0])
  );

  shift_add_mult_ctrl #(.WIDTH(16), .EARLY_TERM(1'b0)) u_dut_full (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .A(a[1]), .B(b[1]),
    .READY(ready[1]), .BUSY(busy[1]), .DONE(done[1]), .P(p[1]), .SHAMT(shamt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] ep, input logic [31:0] en);
    exp_t e;
    e.p = ep;
    e.n = en;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: pops expectations on DONE, tracks RUN length and shift index.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        busy_cnt[k]  = 0;
        done_prev[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready_busy_excl%0d", k), 32'(ready[k] & busy[k]), 32'd0);
        if (busy[k]) begin
          chk($sformatf("shamt%0d", k), 32'(shamt[k]), 32'(busy_cnt[k]));
          busy_cnt[k]++;
        end
        if (done[k]) begin
          chk($sformatf("done_pulse%0d", k), 32'(done_prev[k]), 32'd0);
          chk($sformatf("done_expected%0d", k),
              32'((k == 0) ? (q0.size() != 0) : (q1.size() != 0)), 32'd1);
          if ((k == 0 && q0.size() != 0) || (k == 1 && q1.size() != 0)) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("product%0d", k), p[k], e.p);
            chk($sformatf("run_cycles%0d", k), 32'(busy_cnt[k]), e.n);
          end
          busy_cnt[k] = 0;
        end
        done_prev[k] = done[k];
      end
    end
  end

  task automatic wait_ready(input int k);
    int i;
    i = 0;
    while (!ready[k] && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("wait_ready%0d", k), 32'(ready[k]), 32'd1);
  endtask

  task automatic issue(input int k, input logic [15:0] va, input logic [15:0] vb,
                       input logic [31:0] ep, input logic [31:0] en);
    wait_ready(k);
    @(negedge clk);
    a[k]     = va;
    b[k]     = vb;
    start[k] = 1'b1;
    push_exp(k, ep, en);
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask

  initial begin
    int i;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      a[k]     = '0;
      b[k]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_p%0d", k), p[k], 32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst_shamt%0d", k), 32'(shamt[k]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'd1);

    issue(0, 16'd3, 16'd5, 32'h0000_000F, 32'd3);
    issue(1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32'd16);
    issue(0, 16'h1234, 16'h0000, 32'h0000_0000, 32'd1);
    issue(0, 16'h0003, 16'h8000, 32'h0001_8000, 32'd16);
    issue(1, 16'h0003, 16'h0005, 32'h0000_000F, 32'd16);

    issue(0, 16'd7, 16'd9, 32'h0000_003F, 32'd4);
    @(negedge clk);
    chk("busy_during_ignored_start", 32'(busy[0]), 32'd1);
    a[0] = 16'd2;
    b[0] = 16'd2;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;

    // Mid-operation asynchronous reset; its expectation is flushed by the monitor.
    issue(0, 16'h00FF, 16'h0F0F, 32'h0000_0000, 32'd12);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_p", p[0], 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_done", 32'(done[0]), 32'd0);
    chk("midrst_shamt", 32'(shamt[0]), 32'd0);
    chk("midrst_ready", 32'(ready[0]), 32'd0);
    chk("midrst_p_full", p[1], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("postrst_ready", 32'(ready[0]), 32'd1);

    // Back-to-back with START held high.
    @(negedge clk);
    a[0] = 16'd10;
    b[0] = 16'd10;
    start[0] = 1'b1;
    push_exp(0, 32'd100, 32'd4);
    @(posedge clk);
    #1;
    a[0] = 16'd4;
    b[0] = 16'd4;
    push_exp(0, 32'd16, 32'd3);
    i = 0;
    @(negedge clk);
    while (!done[0] && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("b2b_first_done", 32'(done[0]), 32'd1);
    @(negedge clk);
    chk("b2b_idle_gap", 32'(ready[0]), 32'd1);
    @(negedge clk);
    chk("b2b_reaccept", 32'(busy[0]), 32'd1);
    start[0] = 1'b0;

    i = 0;
    while ((q0.size() != 0 || q1.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
